dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder at the far end of the core's DREQ/DRW/DADDR/DWDATA/DRDATA port.
//  Stores and returns 32-bit words from a sync single-port array with fixed 1-cycle read latency.
//  Clears the array after reset. Exposes a loader port so benches/boot logic can preload data.
//  Sits beside the CPU top; one instance per data port.
// PARAMETERS
//  DW      32  data word width
//  AW      30  word-address width on the core side
//  DEPTH_L 10  log2 of words implemented (1024 words); addresses at or above 2**DEPTH_L are out of range
//  CLR_EN  1   1 = zero-fill the array after reset; 0 = skip straight to RUN
// PORTS
//  CLK      in   1        clock, rising edge
//  RST      in   1        asynchronous reset, active-high
//  DREQ     in   1        core access request, active-high
//  DRW      in   1        1 = read, 0 = write; sampled only when DREQ=1
//  DADDR    in   AW       word address
//  DWDATA   in   DW       write data
//  DRDATA   out  DW       read data, valid the cycle after a read request
//  READY    out  1        1 = array initialised, accepting accesses
//  LD_EN    in   1        loader write request
//  LD_ADDR  in   DEPTH_L  loader word address
//  LD_DATA  in   DW       loader write data
//  LD_ACK   out  1        1 = loader write accepted this cycle (combinational)
//  ERR      out  1        sticky: out-of-range core access seen; cleared only by RST
// BEHAVIOUR
//  Reset values: DRDATA=0, READY=0, ERR=0, clear counter=0. FSM enters CLEAR, or RUN when CLR_EN=0.
//  FSM states:
//   CLEAR: write 0 to address cnt each cycle, cnt++. At cnt==2**DEPTH_L-1 the last write happens,
//          then go to RUN and set READY=1. Takes 2**DEPTH_L cycles.
//   RUN:   serve core and loader accesses. The FSM leaves RUN only on RST.
//  Core accesses in CLEAR are ignored: no write, DRDATA=0 next cycle, ERR unchanged. LD_ACK=0 in CLEAR.
//  Read (RUN, DREQ=1, DRW=1, in range): DRDATA at edge N+1 = mem[DADDR] as of request cycle N.
//  Write (RUN, DREQ=1, DRW=0, in range): mem[DADDR] <= DWDATA at edge N+1. DRDATA holds its value.
//  Read in cycle N+1 of an address written in cycle N returns the new data. No bypass needed;
//   the write is committed first.
//  DRDATA holds its last value on cycles with DREQ=0 and on write cycles.
//  Out-of-range (DADDR[AW-1:DEPTH_L]!=0):
//   - write is dropped; read returns 0.
//   - ERR<=1 at the next edge.
//  Loader arbitration: LD_ACK = (state==RUN) && LD_EN && !DREQ. Core always wins.
//   Loader holds LD_EN/LD_ADDR/LD_DATA until LD_ACK. An acked write commits at the next edge.
//  Only one array port: exactly one of {clear write, core access, loader write} per cycle.
//  RST asserted mid-CLEAR or mid-RUN: FSM->CLEAR, cnt=0, outputs to reset values immediately.
//   Array contents are undefined until the clear finishes.
//  Address arithmetic: cnt is DEPTH_L+1 bits so the terminal compare cannot wrap silently.
// STRUCTURE
//  Shared package toy_mem_pkg:
//   - state encoding (ST_CLEAR=1'b0, ST_RUN=1'b1)
//   - DW/AW defaults
//   - RD=1'b1 / WR=1'b0 DRW encodings
//  Sub-module sram_1rw: DEPTH_L x DW synchronous array. Ports CLK, CE, WE, A, DI, DO. Registered DO, no reset.
//  Top-level logic: FSM, clear counter, port arbitration/mux, range check, ERR flop, DRDATA hold register.
// TESTING
//  1 Reset, DEPTH_L=4, CLR_EN=1 -> READY rises exactly 16 cycles after RST deasserts; then read of each addr 0..15 returns 0.
//  2 Write 0xDEADBEEF @5, read @5 next cycle -> DRDATA=0xDEADBEEF one cycle after the read; DRDATA unchanged during the write cycle.
//  3 LD_EN with DREQ=1 for 3 cycles -> LD_ACK=0 for those 3 cycles, LD_ACK=1 when DREQ drops; loaded 0x1234 @7 reads back 0x1234.
//  4 Read @0x400 with DEPTH_L=10 -> DRDATA=0, ERR=1 and stays 1. Write @0x400 leaves mem[0] unchanged.
//  5 Core write @3 issued during CLEAR -> ignored; after READY, read @3 returns 0. ERR=0.
//  6 RST pulsed at cycle 8 of CLEAR -> READY=0, DRDATA=0, and the clear restarts with a full 2**DEPTH_L-cycle count.

Source files
------------

// File: rtl/toy_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, default widths and DRW encodings.
package toy_mem_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 30;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

endpackage

// File: rtl/sram_1rw.sv
// Single-port synchronous RAM, one access per cycle.
// Registered read data, no reset on array or output.
module sram_1rw #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          CE,
    input  logic          WE,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] DI,
    output logic [DW-1:0] DO
);

    logic [DW-1:0] mem [2**AW];

    // Write commits at the edge; a read updates DO at the same edge.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (WE) begin
                mem[A] <= DI;
            end else begin
                DO <= mem[A];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: clear-after-reset FSM, core/loader
// arbitration onto one array port, range check and sticky error.
module dmem_responder
    import toy_mem_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int DEPTH_L = 10,
    parameter bit CLR_EN  = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DREQ,
    input  logic               DRW,
    input  logic [AW-1:0]      DADDR,
    input  logic [DW-1:0]      DWDATA,
    output logic [DW-1:0]      DRDATA,
    output logic               READY,
    input  logic               LD_EN,
    input  logic [DEPTH_L-1:0] LD_ADDR,
    input  logic [DW-1:0]      LD_DATA,
    output logic               LD_ACK,
    output logic               ERR
);

    localparam logic [DEPTH_L:0] CNT_LAST = {1'b0, {DEPTH_L{1'b1}}};
    localparam logic [DEPTH_L:0] CNT_ONE  = {{DEPTH_L{1'b0}}, 1'b1};

    state_t             state;
    logic [DEPTH_L:0]   cnt;
    logic               ready_q;
    logic               err_q;
    logic               rd_q;
    logic [DW-1:0]      hold_q;
    logic [DW-1:0]      sram_do;

    logic               running;
    logic               oor;
    logic               clr_go;
    logic               core_go;
    logic               ld_go;
    logic               rd_go;
    logic               zero_rd;

    logic               ce;
    logic               we;
    logic [DEPTH_L-1:0] a;
    logic [DW-1:0]      di;

    assign running = (state == ST_RUN);
    assign oor     = |DADDR[AW-1:DEPTH_L];
    assign clr_go  = (state == ST_CLEAR);
    assign core_go = running && DREQ && !oor;
    assign ld_go   = running && LD_EN && !DREQ;
    assign rd_go   = core_go && (DRW == RD);
    assign zero_rd = DREQ && (!running || (oor && (DRW == RD)));

    assign LD_ACK = ld_go;
    assign READY  = ready_q;
    assign ERR    = err_q;
    assign DRDATA = rd_q ? sram_do : hold_q;

    // Clear sweep, then serve; ERR latches out-of-range core accesses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= CLR_EN ? ST_CLEAR : ST_RUN;
            cnt     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                    if (DREQ && oor) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // One owner of the array port per cycle: clear, core, then loader.
    always_comb begin
        ce = 1'b0;
        we = 1'b0;
        a  = '0;
        di = '0;
        unique case (1'b1)
            clr_go: begin
                ce = 1'b1;
                we = 1'b1;
                a  = cnt[DEPTH_L-1:0];
                di = '0;
            end
            core_go: begin
                ce = 1'b1;
                we = (DRW == WR);
                a  = DADDR[DEPTH_L-1:0];
                di = DWDATA;
            end
            ld_go: begin
                ce = 1'b1;
                we = 1'b1;
                a  = LD_ADDR;
                di = LD_DATA;
            end
            default: begin
                ce = 1'b0;
            end
        endcase
    end

    // Track whether DRDATA shows fresh RAM data or the held value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q   <= 1'b0;
            hold_q <= '0;
        end else begin
            rd_q   <= rd_go;
            hold_q <= zero_rd ? '0 : DRDATA;
        end
    end

    sram_1rw #(
        .AW (DEPTH_L),
        .DW (DW)
    ) u_sram (
        .CLK (CLK),
        .CE  (ce),
        .WE  (we),
        .A   (a),
        .DI  (di),
        .DO  (sram_do)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 16-word array.
// Expected values are hand-computed constants.
module tb_dmem_responder;
    import toy_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq = 1'b0;
    logic        drw = 1'b0;
    logic [29:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [31:0] drdata;
    logic        ready;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ack;
    logic        err;

    int checks = 0;
    int failures = 0;
    int n;

    dmem_responder #(
        .DW      (32),
        .AW      (30),
        .DEPTH_L (4),
        .CLR_EN  (1'b1)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .DREQ    (dreq),
        .DRW     (drw),
        .DADDR   (daddr),
        .DWDATA  (dwdata),
        .DRDATA  (drdata),
        .READY   (ready),
        .LD_EN   (ld_en),
        .LD_ADDR (ld_addr),
        .LD_DATA (ld_data),
        .LD_ACK  (ld_ack),
        .ERR     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [29:0] ad);
        dreq  = 1'b1;
        drw   = RD;
        daddr = ad;
        tick();
        dreq  = 1'b0;
    endtask

    task automatic wr(input logic [29:0] ad, input logic [31:0] d);
        dreq   = 1'b1;
        drw    = WR;
        daddr  = ad;
        dwdata = d;
        tick();
        dreq   = 1'b0;
    endtask

    task automatic ld(input logic [3:0] ad, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = ad;
        ld_data = d;
        #1;
        check("ld_ack", {31'b0, ld_ack}, 32'd1);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 64) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);

        rst = 1'b0;
        repeat (8) tick();
        check("clr_mid_ready", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("clr_rst_ready", {31'b0, ready}, 32'd0);
        check("clr_rst_drdata", drdata, 32'd0);
        tick();
        rst = 1'b0;

        n = 0;
        while (!ready && n < 64) begin
            tick();
            n++;
            if (n == 10) begin
                dreq    = 1'b1;
                drw     = WR;
                daddr   = 30'd3;
                dwdata  = 32'hAAAA5555;
                ld_en   = 1'b1;
                ld_addr = 4'd3;
                ld_data = 32'h77;
                #1;
                check("clr_ld_ack", {31'b0, ld_ack}, 32'd0);
            end else if (n == 11) begin
                dreq  = 1'b0;
                ld_en = 1'b0;
                check("clr_core_drdata", drdata, 32'd0);
            end
        end
        check("ready_cycles", 32'(n), 32'd16);
        check("clr_err", {31'b0, err}, 32'd0);
        rd(30'd3);
        check("rd3_after_clr", drdata, 32'd0);

        dreq    = 1'b1;
        drw     = RD;
        daddr   = 30'd0;
        ld_en   = 1'b1;
        ld_addr = 4'd7;
        ld_data = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_ack_blocked", {31'b0, ld_ack}, 32'd0);
            tick();
        end
        dreq = 1'b0;
        #1;
        check("ld_ack_free", {31'b0, ld_ack}, 32'd1);
        tick();
        ld_en = 1'b0;
        rd(30'd7);
        check("rd7_loaded", drdata, 32'h1234);

        wr(30'd5, 32'hDEADBEEF);
        check("wr_hold", drdata, 32'h1234);
        rd(30'd5);
        check("rd5", drdata, 32'hDEADBEEF);
        tick();
        check("idle_hold", drdata, 32'hDEADBEEF);

        wr(30'd15, 32'hCAFE000F);
        rd(30'd15);
        check("rd15_top", drdata, 32'hCAFE000F);

        ld(4'd0, 32'h55);
        rd(30'd0);
        check("rd0_loaded", drdata, 32'h55);
        check("err_pre_oor", {31'b0, err}, 32'd0);
        rd(30'h10);
        check("oor_rd_zero", drdata, 32'd0);
        check("oor_err", {31'b0, err}, 32'd1);
        wr(30'h10, 32'hBAD);
        rd(30'd0);
        check("oor_wr_drop", drdata, 32'h55);
        wr(30'h400, 32'hBADBAD);
        check("oor_wr_hold", drdata, 32'h55);
        rd(30'h400);
        check("oor_rd400", drdata, 32'd0);
        rd(30'd0);
        check("oor_wr400_drop", drdata, 32'h55);
        check("err_sticky", {31'b0, err}, 32'd1);

        rst = 1'b1;
        #1;
        check("run_rst_drdata", drdata, 32'd0);
        check("run_rst_err", {31'b0, err}, 32'd0);
        check("run_rst_ready", {31'b0, ready}, 32'd0);
        tick();
        rst = 1'b0;
        wait_ready(n);
        check("ready_cycles2", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            rd(30'(i));
            check($sformatf("clr_rd%0d", i), drdata, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
